seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

- Drives a 4-digit common-anode 7-segment display from a 14-bit binary value.
- A load is handshaked in, then converted to four BCD digits by a sequential shift-add-3 (double-dabble) engine, one bit per clock.
- Digits are time-multiplexed onto shared segment lines with a programmable refresh divider and active-low one-hot anode scanning.
- Sits between the value-producing logic (counters, ALU results) and the board display pins.

## Interface

Parameters:
- REFRESH_DIV, default 100000: clocks per digit slot (1 kHz digit rate at 100 MHz); legal range ≥ 2.

Ports:
- clk  in  1  system clock, one clock domain; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- value  in  14  binary value to display; legal range 0–9999.
- load  in  1  request to capture `value`; accepted only when busy=0.
- blank_lz  in  1  leading-zero blanking enable, sampled live.
- busy  out  1  high while a conversion is in progress.
- an  out  4  anode enables, active-low one-hot.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.

## Operation

Reset values:
- busy=0.
- Digit index=0, so an=4'b1110.
- Displayed digits all 0, overflow flag=0, so seg=7'b1000000 ("0").
- Refresh counter=0.

Load and conversion:
- Load accept: in a cycle with load=1 and busy=0, capture `value` into the shift register and clear the BCD scratch.
- busy goes high the next cycle.
- load while busy=1 is ignored. It is not queued.
- Overflow check at accept: value>9999 sets pending overflow. Conversion still runs, with fixed length.
- FSM states: IDLE, SHIFT (14 iterations), COMMIT.
  - IDLE→SHIFT on accepted load.
  - Each SHIFT cycle: add 3 to every BCD nibble ≥5, then shift left one bit. Bit counter counts 13 down to 0.
  - SHIFT→COMMIT when the bit counter reaches 0.
  - COMMIT copies the scratch nibbles into the displayed digit registers and the overflow flag, then returns to IDLE.
- Until COMMIT, the display keeps showing the previous digits.

Scanning:
- The refresh counter counts 0..REFRESH_DIV-1 continuously, independent of the FSM.
- On wrap, the digit index advances 0→1→2→3→0.
- an[idx]=0, all other bits 1.
- Digit 0 is the rightmost digit (ones).

Segment selection, in priority order:
1. Overflow flag set: every digit shows dash 7'b0111111.
2. blank_lz=1 and digit idx>0 is above the most-significant nonzero digit: 7'b1111111. Digit 0 is never blanked, so value 0 shows "0".
3. Otherwise: standard decode of the digit value. Nibbles ≥10 cannot occur after conversion; the decoder still maps them to 7'b1111111.

Reset mid-conversion aborts: FSM→IDLE, digits cleared to 0.

## Timing

- Load accepted at edge N: busy=1 from N+1 through N+15 (14 SHIFT + 1 COMMIT cycles), busy=0 at N+16.
- New digits are visible on seg from N+16.
- Earliest next accepted load: edge N+16.
- an and seg are both functions of registered state (idx, digits, flags). They change in the same cycle, with no glitch-free guarantee beyond that.
- Digit period is REFRESH_DIV clocks; full frame is 4·REFRESH_DIV clocks.
- A COMMIT landing mid-slot takes effect immediately on the current digit.

## Structure

- Shared package seg7_pkg:
  - segment constants SEG_BLANK=7'b1111111 and SEG_DASH=7'b0111111.
  - digit-count localparam NDIG=4.
  - FSM state enum {IDLE, SHIFT, COMMIT}.
- Sub-module seg7_decode: purely combinational 4-bit digit → 7-bit active-low pattern, patterns 0–9 as the team standard, default blank.
- Top module holds the FSM, the double-dabble datapath, the refresh counter and the blanking/overflow mux.

## Test plan

Run with REFRESH_DIV=4.

1. Reset asserted mid-cycle with no clock edge → an=4'b1110, seg=7'b1000000, busy=0 immediately.
2. load value=1234, blank_lz=0 → busy high for 15 cycles. Then over one frame, an=1110/1101/1011/0111 paired with seg = "4" 0011001, "3" 0110000, "2" 0100100, "1" 1111001.
3. load value=7, blank_lz=1 → digit0 shows 1111000; digits 1–3 show 7'b1111111. Load value=0 → digit0 shows 1000000, others blank.
4. load value=12000 → all four digits show 7'b0111111 after COMMIT.
5. load value=5678, then pulse load with value=9999 during busy → display shows 5678, and the second load is not captured.
6. Assert reset at SHIFT iteration 5 after loading 4321 → display returns to all "0" and busy=0. A new load of 42 then completes normally in 15 busy cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, types and helpers for the 4-digit
// 7-segment scan controller.
//   - SEG_BLANK / SEG_DASH : active-low segment patterns {g,f,e,d,c,b,a}
//   - NDIG, VAL_W, BCD_W   : display geometry and datapath widths
//   - state_t              : conversion FSM states
//   - dd_adjust()          : one double-dabble correction step (add 3 to
//                            every BCD nibble >= 5)
package seg7_pkg;

  localparam int NDIG  = 4;
  localparam int VAL_W = 14;
  localparam int BCD_W = 4 * NDIG;

  localparam logic [6:0]       SEG_BLANK = 7'b1111111;
  localparam logic [6:0]       SEG_DASH  = 7'b0111111;
  localparam logic [VAL_W-1:0] VAL_MAX   = 14'd9999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Correction applied before each shift so that a nibble reaching >= 10
  // after the shift carries into the next nibble.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    logic [3:0]       nib;
    res = bcd;
    for (int i = 0; i < NDIG; i++) begin
      nib = bcd[4*i +: 4];
      if (nib >= 4'd5) res[4*i +: 4] = nib + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_decode.sv
// seg7_decode: purely combinational BCD digit to active-low 7-segment
// pattern, bit order {g,f,e,d,c,b,a}. Codes 10..15 map to blank.
//   digit : in  4  BCD digit
//   seg   : out 7  active-low segment pattern
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 4-digit common-anode 7-segment driver.
// A 14-bit binary value is handshaked in, converted to BCD by a
// sequential shift-add-3 engine (one bit per clock), committed to the
// displayed digit registers, and scanned out one digit per refresh slot.
//   clk      : in  1   system clock
//   reset    : in  1   asynchronous active-high reset
//   value    : in  14  binary value to display (0..9999 legal)
//   load     : in  1   capture request, honoured only while busy=0
//   blank_lz : in  1   leading-zero blanking enable (live)
//   busy     : out 1   conversion in progress
//   an       : out 4   anode enables, active-low one-hot
//   seg      : out 7   segments {g,f,e,d,c,b,a}, active-low
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [VAL_W-1:0] value,
  input  logic             load,
  input  logic             blank_lz,
  output logic             busy,
  output logic [NDIG-1:0]  an,
  output logic [6:0]       seg
);

  localparam int               CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  // ---------------------------------------------------------------------
  // Conversion state
  // ---------------------------------------------------------------------
  state_t                    state_q,    state_d;
  logic [VAL_W-1:0]          shreg_q,    shreg_d;
  logic [BCD_W-1:0]          bcd_q,      bcd_d;
  logic [3:0]                bitcnt_q,   bitcnt_d;
  logic                      ovf_pend_q, ovf_pend_d;

  // Displayed state
  logic [NDIG-1:0][3:0]      digits_q,   digits_d;
  logic                      ovf_q,      ovf_d;

  // Scan state
  logic [CNT_W-1:0]          refcnt_q,   refcnt_d;
  logic [1:0]                idx_q,      idx_d;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bcd_d      = bcd_q;
    bitcnt_d   = bitcnt_q;
    ovf_pend_d = ovf_pend_q;
    digits_d   = digits_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          shreg_d    = value;
          bcd_d      = '0;
          bitcnt_d   = 4'(VAL_W - 1);
          // Out-of-range values still run the full-length conversion; the
          // flag only selects the dash pattern once committed.
          ovf_pend_d = (value > VAL_MAX);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, shreg_d} = {dd_adjust(bcd_q), shreg_q} << 1;
        if (bitcnt_q == 4'd0) begin
          state_d = COMMIT;
        end else begin
          bitcnt_d = bitcnt_q - 4'd1;
        end
      end
      COMMIT: begin
        digits_d = bcd_q;
        ovf_d    = ovf_pend_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Free-running slot counter; the FSM never stalls the scan.
  always_comb begin
    refcnt_d = refcnt_q + CNT_W'(1);
    idx_d    = idx_q;
    if (refcnt_q == CNT_LAST) begin
      refcnt_d = '0;
      idx_d    = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bcd_q      <= '0;
      bitcnt_q   <= '0;
      ovf_pend_q <= 1'b0;
      digits_q   <= '0;
      ovf_q      <= 1'b0;
      refcnt_q   <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bcd_q      <= bcd_d;
      bitcnt_q   <= bitcnt_d;
      ovf_pend_q <= ovf_pend_d;
      digits_q   <= digits_d;
      ovf_q      <= ovf_d;
      refcnt_q   <= refcnt_d;
      idx_q      <= idx_d;
    end
  end

  assign busy = (state_q != IDLE);

  // ---------------------------------------------------------------------
  // Display path
  // ---------------------------------------------------------------------
  logic [NDIG-1:0][6:0] dec_seg;

  for (genvar g = 0; g < NDIG; g++) begin : g_dec
    seg7_decode u_dec (
      .digit (digits_q[g]),
      .seg   (dec_seg[g])
    );
  end

  // lz[i] is set when digit i and every more-significant digit are zero,
  // i.e. digit i lies above the most-significant nonzero digit.
  logic [NDIG-1:0] lz;

  always_comb begin
    lz[NDIG-1] = (digits_q[NDIG-1] == 4'd0);
    for (int i = NDIG - 2; i >= 0; i--) begin
      lz[i] = lz[i+1] && (digits_q[i] == 4'd0);
    end
  end

  always_comb begin
    seg = dec_seg[idx_q];
    if (ovf_q) begin
      seg = SEG_DASH;
    end else if (blank_lz && (idx_q != 2'd0) && lz[idx_q]) begin
      seg = SEG_BLANK;
    end
  end

  assign an = ~(NDIG'(1) << idx_q);

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

  localparam int DIV = 4;

  localparam logic [6:0] S0    = 7'b1000000;
  localparam logic [6:0] S1    = 7'b1111001;
  localparam logic [6:0] S2    = 7'b0100100;
  localparam logic [6:0] S3    = 7'b0110000;
  localparam logic [6:0] S4    = 7'b0011001;
  localparam logic [6:0] S5    = 7'b0010010;
  localparam logic [6:0] S6    = 7'b0000010;
  localparam logic [6:0] S7    = 7'b1111000;
  localparam logic [6:0] S8    = 7'b0000000;
  localparam logic [6:0] SBLK  = 7'b1111111;
  localparam logic [6:0] SDASH = 7'b0111111;

  logic        clk;
  logic        reset;
  logic [13:0] value;
  logic        load;
  logic        blank_lz;
  logic        busy;
  logic [3:0]  an;
  logic [6:0]  seg;

  int checks = 0;
  int passed = 0;

  logic [6:0] fr_seg [4];
  bit         fr_ok;

  seg7_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .load     (load),
    .blank_lz (blank_lz),
    .busy     (busy),
    .an       (an),
    .seg      (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Present value with load=1 for one cycle; returns on the negedge just
  // after the accepting edge.
  task automatic do_load(input logic [13:0] v);
    @(negedge clk);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Align to the first cycle of slot 0, then record one full frame of seg
  // per slot; fr_ok drops if an is wrong at any cycle or seg is unstable
  // within a slot.
  task automatic capture_frame();
    logic [3:0] prev;
    logic [3:0] oh;
    bit         found;
    int         guard;
    fr_ok = 1'b1;
    found = 1'b0;
    guard = 0;
    prev  = an;
    for (int i = 0; i < 4; i++) fr_seg[i] = 'x;
    while (!found && guard < 12 * DIV) begin
      @(negedge clk);
      guard++;
      if (an === 4'b1110 && prev === 4'b0111) found = 1'b1;
      else prev = an;
    end
    if (!found) begin
      fr_ok = 1'b0;
      return;
    end
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < DIV; c++) begin
        if (k != 0 || c != 0) @(negedge clk);
        oh = 4'b0001 << k;
        if (an !== ~oh) fr_ok = 1'b0;
        if (c == 0) fr_seg[k] = seg;
        else if (seg !== fr_seg[k]) fr_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; value = '0; load = 1'b0; blank_lz = 1'b0;
    #3 reset = 1'b1;
    #1;
    checks++; if (an !== 4'b1110) $display("FAIL reset_an: got %b expected %b", an, 4'b1110); else passed++;
    checks++; if (seg !== S0) $display("FAIL reset_seg: got %b expected %b", seg, S0); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int n;
    logic [6:0] e [4];
    blank_lz = 1'b0;
    do_load(14'd1234);
    checks++; if (busy !== 1'b1) $display("FAIL basic_busy_rise: got %b expected 1", busy); else passed++;
    count_busy(n);
    checks++; if (n != 15) $display("FAIL basic_busy_len: got %0d expected 15", n); else passed++;
    capture_frame();
    e[0] = S4; e[1] = S3; e[2] = S2; e[3] = S1;
    checks++; if (fr_ok !== 1'b1) $display("FAIL basic_scan: got %b expected 1", fr_ok); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fr_seg[i] !== e[i]) $display("FAIL basic_seg%0d: got %b expected %b", i, fr_seg[i], e[i]);
      else passed++;
    end
  endtask

  task automatic test_blank();
    int n;
    logic [6:0] e [4];
    blank_lz = 1'b1;
    do_load(14'd7);
    count_busy(n);
    capture_frame();
    e[0] = S7; e[1] = SBLK; e[2] = SBLK; e[3] = SBLK;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fr_seg[i] !== e[i]) $display("FAIL blank7_seg%0d: got %b expected %b", i, fr_seg[i], e[i]);
      else passed++;
    end
    do_load(14'd0);
    count_busy(n);
    capture_frame();
    e[0] = S0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fr_seg[i] !== e[i]) $display("FAIL blank0_seg%0d: got %b expected %b", i, fr_seg[i], e[i]);
      else passed++;
    end
    // blanking is sampled live
    blank_lz = 1'b0;
    capture_frame();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fr_seg[i] !== S0) $display("FAIL live_seg%0d: got %b expected %b", i, fr_seg[i], S0);
      else passed++;
    end
    // interior zeros stay visible
    blank_lz = 1'b1;
    do_load(14'd1000);
    count_busy(n);
    capture_frame();
    e[0] = S0; e[1] = S0; e[2] = S0; e[3] = S1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fr_seg[i] !== e[i]) $display("FAIL blank1000_seg%0d: got %b expected %b", i, fr_seg[i], e[i]);
      else passed++;
    end
  endtask

  task automatic test_overflow();
    int n;
    blank_lz = 1'b1;
    do_load(14'd12000);
    count_busy(n);
    checks++; if (n != 15) $display("FAIL ovf_busy_len: got %0d expected 15", n); else passed++;
    capture_frame();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fr_seg[i] !== SDASH) $display("FAIL ovf_seg%0d: got %b expected %b", i, fr_seg[i], SDASH);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit hold_ok;
    bit idle_ok;
    logic [6:0] e [4];
    blank_lz = 1'b0;
    hold_ok  = 1'b1;
    idle_ok  = 1'b1;
    do_load(14'd5678);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      if (seg !== SDASH) hold_ok = 1'b0;
      if (n == 3) begin value = 14'd9999; load = 1'b1; end
      if (n == 4) load = 1'b0;
      n++;
      @(negedge clk);
    end
    checks++; if (hold_ok !== 1'b1) $display("FAIL b2b_hold_prev: got %b expected 1", hold_ok); else passed++;
    checks++; if (n != 15) $display("FAIL b2b_busy_len: got %0d expected 15", n); else passed++;
    repeat (3) begin
      @(negedge clk);
      if (busy !== 1'b0) idle_ok = 1'b0;
    end
    checks++; if (idle_ok !== 1'b1) $display("FAIL b2b_not_queued: got %b expected 1", idle_ok); else passed++;
    capture_frame();
    e[0] = S8; e[1] = S7; e[2] = S6; e[3] = S5;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fr_seg[i] !== e[i]) $display("FAIL b2b_seg%0d: got %b expected %b", i, fr_seg[i], e[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_abort();
    int n;
    logic [6:0] e [4];
    blank_lz = 1'b0;
    do_load(14'd4321);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else passed++;
    checks++; if (an !== 4'b1110) $display("FAIL abort_an: got %b expected %b", an, 4'b1110); else passed++;
    checks++; if (seg !== S0) $display("FAIL abort_seg: got %b expected %b", seg, S0); else passed++;
    @(negedge clk);
    reset = 1'b0;
    capture_frame();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fr_seg[i] !== S0) $display("FAIL abort_frame%0d: got %b expected %b", i, fr_seg[i], S0);
      else passed++;
    end
    do_load(14'd42);
    count_busy(n);
    checks++; if (n != 15) $display("FAIL abort_reload_busy: got %0d expected 15", n); else passed++;
    capture_frame();
    e[0] = S2; e[1] = S4; e[2] = S0; e[3] = S0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fr_seg[i] !== e[i]) $display("FAIL abort_reload_seg%0d: got %b expected %b", i, fr_seg[i], e[i]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blank();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
